// File: rtl/frame_seq_pkg.sv
// ---------------------------------------------------------------------------
// frame_seq_pkg : shared state type and default widths for the frame sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package frame_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ERASE  = 2'd1,
    UPDATE = 2'd2,
    DRAW   = 2'd3
  } seq_state_e;

  localparam int unsigned C_FRAME_CNT_W = 16;
  localparam int unsigned C_OVR_CNT_W   = 8;

endpackage

`default_nettype wire

// File: rtl/frame_tick_sequencer_toggle_edge_detect.sv
// ---------------------------------------------------------------------------
// toggle_edge_detect : turns a level-toggling enable into a combinational edge
//                      flag and a registered one-cycle tick
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module toggle_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic toggle_in,
  output logic toggle_edge,
  output logic tick
);

  logic prev_q, prev_d;
  logic tick_q, tick_d;

  assign toggle_edge = toggle_in ^ prev_q;

  always_comb begin
    prev_d = toggle_in;
    tick_d = toggle_edge;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

`default_nettype wire

// File: rtl/frame_tick_sequencer.sv
// ---------------------------------------------------------------------------
// frame_tick_sequencer : converts rate-divider toggles into frame ticks and
//                        walks erase -> update -> draw through req/done
// Optional feature macro: FRAME_OVERRUN_CNT_EN (saturating dropped-tick count)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module frame_tick_sequencer
  import frame_seq_pkg::*;
#(
  parameter int unsigned FRAME_CNT_W = C_FRAME_CNT_W
`ifdef FRAME_OVERRUN_CNT_EN
  , parameter int unsigned OVR_CNT_W = C_OVR_CNT_W
`endif
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   rate_toggle,
  output logic                   frame_tick,
  output logic                   erase_req,
  input  logic                   erase_done,
  output logic                   update_req,
  input  logic                   update_done,
  output logic                   draw_req,
  input  logic                   draw_done,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_count
`ifdef FRAME_OVERRUN_CNT_EN
  , output logic [OVR_CNT_W-1:0] overrun_count
`endif
);

  seq_state_e             state_q, state_d;
  logic                   pending_q, pending_d;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
  logic                   toggle_edge;
  logic                   busy_edge;

  toggle_edge_detect u_edge (
    .clk         (clk),
    .reset_n     (reset_n),
    .toggle_in   (rate_toggle),
    .toggle_edge (toggle_edge),
    .tick        (frame_tick)
  );

  // The draw-done cycle hands any new edge straight to the next frame instead.
  assign busy_edge = toggle_edge && (state_q != IDLE) && !((state_q == DRAW) && draw_done);

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    frame_count_d = frame_count_q;
    case (state_q)
      IDLE: begin
        if (toggle_edge || pending_q) begin
          state_d   = ERASE;
          pending_d = 1'b0;
        end
      end
      ERASE:  if (erase_done)  state_d = UPDATE;
      UPDATE: if (update_done) state_d = DRAW;
      DRAW: begin
        if (draw_done) begin
          frame_count_d = frame_count_q + FRAME_CNT_W'(1);
          if (pending_q || toggle_edge) begin
            state_d   = ERASE;
            pending_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (busy_edge && !pending_q) pending_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pending_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      frame_count_q <= frame_count_d;
    end
  end

`ifdef FRAME_OVERRUN_CNT_EN
  logic [OVR_CNT_W-1:0] overrun_count_q, overrun_count_d;

  always_comb begin
    overrun_count_d = overrun_count_q;
    if (busy_edge && pending_q && (overrun_count_q != '1))
      overrun_count_d = overrun_count_q + OVR_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) overrun_count_q <= '0;
    else          overrun_count_q <= overrun_count_d;
  end

  assign overrun_count = overrun_count_q;
`endif

  assign erase_req   = (state_q == ERASE);
  assign update_req  = (state_q == UPDATE);
  assign draw_req    = (state_q == DRAW);
  assign busy        = (state_q != IDLE);
  assign frame_count = frame_count_q;

endmodule

`default_nettype wire
